// File: rtl/sa_pkg.sv
// sa_pkg: FSM state type, default sizes and the saturating accumulate used by systolic_gemm.
// sat_add is only referenced when SA_SATURATE_EN is defined.
package sa_pkg;
    localparam int N_DEF = 4;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 32;

    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;

    // An accumulator already sitting on a rail stays there, so a clamp is sticky down the column.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc, input logic signed [63:0] prod, input int aw);
        logic signed [63:0] hi, lo, s;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s = acc + prod;
        return (acc == hi || acc == lo) ? acc : s > hi ? hi : s < lo ? lo : s;
    endfunction
endpackage

// File: rtl/sa_pe.sv
// sa_pe: weight-stationary PE; weights shift up the column on load, activations move right, sums move down.
// SA_SATURATE_EN selects clamping accumulation instead of two's-complement wrap.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 w_shift,
    input  logic signed [DW-1:0] w_in,
    output logic signed [DW-1:0] w_out,
    input  logic signed [DW-1:0] a_in,
    output logic signed [DW-1:0] a_out,
    input  logic signed [AW-1:0] p_in,
    output logic signed [AW-1:0] p_out
);
    localparam int PW = 2 * DW;
    logic signed [PW-1:0] mul;
    logic signed [AW-1:0] p_next;

    assign mul = PW'(a_in) * PW'(w_out);
`ifdef SA_SATURATE_EN
    assign p_next = AW'(sat_add(64'(p_in), 64'(mul), AW));
`else
    assign p_next = p_in + AW'(mul);
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            w_out <= '0;
            a_out <= '0;
            p_out <= '0;
        end else begin
            if (w_shift) w_out <= w_in;
            if (en) begin
                a_out <= a_in;
                p_out <= p_next;
            end
        end
endmodule

// File: rtl/systolic_gemm.sv
// systolic_gemm: N x N weight-stationary matrix-vector engine with input skew, output deskew and valid/ready streams.
// Define SA_SATURATE_EN for clamping accumulation; otherwise sums wrap modulo 2^AW.
module systolic_gemm
    import sa_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [N*DW-1:0] w_row,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [N*DW-1:0] a_vec,
    input  logic            a_last,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [N*AW-1:0] y_vec,
    output logic            y_last,
    output logic            busy
);
    localparam int CW = $clog2(N);
    localparam int L = 2 * N;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic adv, w_acc, a_acc;
    logic [L:0] vp, lp;
    logic signed [DW-1:0] a_h [N][N];
    logic signed [DW-1:0] w_h [N][N];
    logic signed [AW-1:0] p_h [N][N];
    logic signed [AW-1:0] col [N];
    logic signed [DW-1:0] a_unused [N];
    logic signed [DW-1:0] w_unused [N];

    assign adv = !(y_valid && !y_ready);
    assign w_ready = !rst && (state == IDLE || state == LOAD_W);
    assign a_ready = !rst && (state == IDLE ? !w_valid : state == COMPUTE && adv);
    assign w_acc = w_valid && w_ready;
    assign a_acc = a_valid && a_ready;
    assign busy = state != IDLE;
    assign y_valid = vp[L];
    assign y_last = lp[L];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: begin
                if (w_acc) begin
                    state_nx = LOAD_W;
                    cnt_nx = CW'(1);
                end else if (a_acc) state_nx = a_last ? DRAIN : COMPUTE;
            end
            LOAD_W: begin
                if (w_acc) begin
                    cnt_nx = cnt == CW'(N - 1) ? '0 : cnt + 1'b1;
                    state_nx = cnt == CW'(N - 1) ? IDLE : LOAD_W;
                end
            end
            COMPUTE: state_nx = a_acc && a_last ? DRAIN : COMPUTE;
            default: state_nx = y_valid && y_ready && y_last ? IDLE : DRAIN;
        endcase
    end

    // Valid/last travel alongside the data: stage 0 is the input register, stage 2N the output register.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vp <= '0;
            lp <= '0;
        end else if (adv) begin
            vp <= {vp[L-1:0], a_acc};
            lp <= {lp[L-1:0], a_acc && a_last};
        end

    for (genvar i = 0; i < N; i++) begin : g_row
        logic signed [DW-1:0] sr [i+1];
        always_ff @(posedge clk or posedge rst)
            if (rst) sr <= '{default: '0};
            else if (adv) begin
                sr[0] <= a_vec[i*DW +: DW];
                for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
            end
        assign a_h[i][0] = sr[i];
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0] a_o, w_o;
            logic signed [AW-1:0] p_o;
            sa_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk(clk), .rst(rst), .en(adv), .w_shift(w_acc),
                .w_in(w_h[i][j]), .w_out(w_o),
                .a_in(a_h[i][j]), .a_out(a_o),
                .p_in(p_h[i][j]), .p_out(p_o)
            );
            if (j < N - 1) begin : g_a
                assign a_h[i][j+1] = a_o;
            end else begin : g_ae
                assign a_unused[i] = a_o;
            end
            if (i > 0) begin : g_w
                assign w_h[i-1][j] = w_o;
            end else begin : g_we
                assign w_unused[j] = w_o;
            end
            if (i < N - 1) begin : g_p
                assign p_h[i+1][j] = p_o;
            end else begin : g_pe
                assign col[j] = p_o;
            end
        end
    end

    // Column j leaves the array j cycles late; its deskew chain is N-j deep, the last stage being the output register.
    for (genvar j = 0; j < N; j++) begin : g_out
        logic signed [AW-1:0] ds [N-j];
        assign p_h[0][j] = '0;
        assign w_h[N-1][j] = w_row[j*DW +: DW];
        always_ff @(posedge clk or posedge rst)
            if (rst) ds <= '{default: '0};
            else if (adv) begin
                ds[0] <= col[j];
                for (int k = 1; k < N - j; k++) ds[k] <= ds[k-1];
            end
        assign y_vec[j*AW +: AW] = ds[N-1-j];
    end
endmodule
